// File: rtl/player_packet_rx.sv
// player_packet_rx -- UART receiver and decoder for one-byte player control packets.
//
// The serial line is 8N1, LSB first and idle high. Each well-framed byte is decoded as
//   [7] remote_rst, [6] reserved (must be 0), [5] fire, [4] proj_type, [3:0] lane code.
// Lane codes 1..6 are taken as they are. Code 0 is the sender's reset state and maps to
// lane 3. A reserved bit of 1, or a lane code of 7..15, is rejected with pkt_err.
//
// Parameters
//   CLK_HZ      system clock frequency in Hz
//   BAUD        serial bit rate
//   TIMEOUT_MS  link-loss watchdog period; used only when PKT_TIMEOUT_EN is defined
//
// Ports
//   clk         system clock, rising edge
//   clean_rst   asynchronous active-high reset
//   rx          UART serial input
//   lane        last accepted lane code (1..6; 3 after reset)
//   fire_level  fire bit of the last accepted packet
//   fire_pulse  one-cycle pulse, together with pkt_valid, on a 0->1 fire transition
//   proj_type   projectile-type bit of the last accepted packet
//   remote_rst  reset bit of the last accepted packet
//   pkt_valid   one-cycle pulse for each accepted packet
//   frame_err   one-cycle pulse when the stop bit is low
//   pkt_err     one-cycle pulse for a well-framed but illegal byte
//   link_up     packets are being received
//
// Build option
//   PKT_TIMEOUT_EN  When this macro is defined, a watchdog drops link_up and fire_level
//                   after TIMEOUT_MS without an accepted packet. When it is not defined,
//                   link_up stays set from the first accepted packet until reset.
`timescale 1ns/1ps

module player_packet_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int TIMEOUT_MS = 50
) (
  input  logic       clk,
  input  logic       clean_rst,
  input  logic       rx,
  output logic [3:0] lane,
  output logic       fire_level,
  output logic       fire_pulse,
  output logic       proj_type,
  output logic       remote_rst,
  output logic       pkt_valid,
  output logic       frame_err,
  output logic       pkt_err,
  output logic       link_up
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Input synchronizer and edge detection. The flops reset low, so arming
  // needs a real high level on the line after reset.
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg, armed_reg;
  logic fall_edge;

  always_ff @(posedge clk or posedge clean_rst) begin
    if (clean_rst) begin
      rx_meta_reg <= 1'b0;
      rx_sync_reg <= 1'b0;
      rx_prev_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      armed_reg   <= armed_reg | rx_sync_reg;
    end
  end

  assign fall_edge = rx_prev_reg & ~rx_sync_reg;

  // Free-running 16x oversample tick generator.
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;

  assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge clean_rst) begin
    if (clean_rst)
      div_cnt_reg <= '0;
    else if (tick)
      div_cnt_reg <= '0;
    else
      div_cnt_reg <= div_cnt_reg + 1'b1;
  end

  // Receive FSM
  state_t     state_reg, state_next;
  logic [3:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       byte_done;   // stop bit sampled high; shift_reg holds the byte
  logic       frame_bad;   // stop bit sampled low

  always_ff @(posedge clk or posedge clean_rst) begin
    if (clean_rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    byte_done     = 1'b0;
    frame_bad     = 1'b0;
    case (state_reg)
      IDLE: begin
        tick_cnt_next = '0;
        bit_cnt_next  = '0;
        if (armed_reg && fall_edge)
          state_next = START;
      end
      START: begin
        if (tick) begin
          if (tick_cnt_reg == 4'd7) begin
            // Mid start bit: a high line here means the edge was a glitch.
            tick_cnt_next = '0;
            state_next    = rx_sync_reg ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_reg == 4'd15) begin
            tick_cnt_next = '0;
            shift_next    = {rx_sync_reg, shift_reg[7:1]};
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_next = '0;
              state_next   = STOP;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_reg == 4'd15) begin
            tick_cnt_next = '0;
            state_next    = IDLE;
            byte_done     = rx_sync_reg;
            frame_bad     = ~rx_sync_reg;
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode and output registers
  logic illegal, accept;

  assign illegal = shift_reg[6] | (shift_reg[3:0] > 4'd6);
  assign accept  = byte_done & ~illegal;

`ifdef PKT_TIMEOUT_EN
  localparam int TIMEOUT_CLKS = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int WD_W         = $clog2(TIMEOUT_CLKS + 1);
  logic [WD_W-1:0] wd_cnt_reg;
`endif

  always_ff @(posedge clk or posedge clean_rst) begin
    if (clean_rst) begin
      lane       <= 4'd3;
      fire_level <= 1'b0;
      fire_pulse <= 1'b0;
      proj_type  <= 1'b0;
      remote_rst <= 1'b0;
      pkt_valid  <= 1'b0;
      frame_err  <= 1'b0;
      pkt_err    <= 1'b0;
      link_up    <= 1'b0;
`ifdef PKT_TIMEOUT_EN
      wd_cnt_reg <= '0;
`endif
    end else begin
      pkt_valid  <= 1'b0;
      frame_err  <= 1'b0;
      pkt_err    <= 1'b0;
      fire_pulse <= 1'b0;
      if (frame_bad) begin
        frame_err <= 1'b1;
      end else if (byte_done && illegal) begin
        pkt_err <= 1'b1;
      end else if (accept) begin
        lane       <= (shift_reg[3:0] == 4'd0) ? 4'd3 : shift_reg[3:0];
        fire_level <= shift_reg[5];
        fire_pulse <= shift_reg[5] & ~fire_level;
        proj_type  <= shift_reg[4];
        remote_rst <= shift_reg[7];
        pkt_valid  <= 1'b1;
        link_up    <= 1'b1;
      end
`ifdef PKT_TIMEOUT_EN
      // The watchdog runs only while the link is up. On expiry fire is released
      // without a pulse, and the lane is kept so that the player stays put.
      if (accept) begin
        wd_cnt_reg <= '0;
      end else if (link_up) begin
        if (wd_cnt_reg == WD_W'(TIMEOUT_CLKS - 1)) begin
          wd_cnt_reg <= '0;
          link_up    <= 1'b0;
          fire_level <= 1'b0;
        end else begin
          wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_player_packet_rx.sv
// Scoreboard testbench for player_packet_rx.
// The stimulus drives UART frames and pushes the expected event from a packet-level
// model. A monitor pops that event and compares it whenever the DUT pulses pkt_valid,
// frame_err or pkt_err.
`timescale 1ns/1ps

module tb_player_packet_rx;

  localparam int CLK_HZ     = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int TIMEOUT_MS = 1;
  localparam int BIT_CLKS   = 160;
`ifdef PKT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clean_rst = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] lane;
  logic       fire_level, fire_pulse, proj_type, remote_rst;
  logic       pkt_valid, frame_err, pkt_err, link_up;

  player_packet_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk(clk), .clean_rst(clean_rst), .rx(rx),
    .lane(lane), .fire_level(fire_level), .fire_pulse(fire_pulse),
    .proj_type(proj_type), .remote_rst(remote_rst), .pkt_valid(pkt_valid),
    .frame_err(frame_err), .pkt_err(pkt_err), .link_up(link_up)
  );

  always #5 clk = ~clk;

  // Event kinds: 0 accepted packet, 1 framing error, 2 illegal packet
  typedef struct {
    int kind;
    int lane;
    int fire;
    int fpulse;
    int proj;
    int rrst;
    int link;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Packet-level model state: the held outputs as the receiver should show them.
  int m_lane, m_fire, m_proj, m_rrst, m_link;
  bit m_any;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  function automatic void model_reset();
    m_lane = 3; m_fire = 0; m_proj = 0; m_rrst = 0; m_link = 0; m_any = 1'b0;
  endfunction

  // With the watchdog built in, each frame starts after the link has gone
  // quiet longer than the timeout. One frame already lasts the full timeout
  // period, and every frame is followed by an idle gap.
  function automatic void expire();
    if (TO_EN && m_any) begin
      m_fire = 0;
      m_link = 0;
    end
  endfunction

  function automatic int gap_clks();
    return TO_EN ? 200 + int'($urandom_range(0, 50)) : int'($urandom_range(0, 60));
  endfunction

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    exp_t e;
    int   code;
    expire();
    code = int'(b[3:0]);
    e.fpulse = 0;
    if (!stop_ok) begin
      e.kind = 1;
    end else if (b[6] || code > 6) begin
      e.kind = 2;
    end else begin
      e.kind   = 0;
      e.fpulse = (b[5] && m_fire == 0) ? 1 : 0;
      m_lane   = (code == 0) ? 3 : code;
      m_fire   = int'(b[5]);
      m_proj   = int'(b[4]);
      m_rrst   = int'(b[7]);
      m_link   = 1;
      m_any    = 1'b1;
    end
    e.lane = m_lane; e.fire = m_fire; e.proj = m_proj; e.rrst = m_rrst; e.link = m_link;
    exp_q.push_back(e);
    $display("TX byte=%02h stop_ok=%0d expect_kind=%0d lane=%0d fire=%0d pulse=%0d",
             b, stop_ok, e.kind, e.lane, e.fire, e.fpulse);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
    hold(stop_ok, BIT_CLKS);
    hold(1'b1, gap);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_lane"}, int'(lane), m_lane);
    check({tag, "_fire_level"}, int'(fire_level), m_fire);
    check({tag, "_proj_type"}, int'(proj_type), m_proj);
    check({tag, "_remote_rst"}, int'(remote_rst), m_rrst);
    check({tag, "_link_up"}, int'(link_up), m_link);
    check({tag, "_pulses"}, int'({pkt_valid, frame_err, pkt_err, fire_pulse}), 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    int   n, act_kind;
    if (!clean_rst && fire_pulse && !pkt_valid)
      check("fire_pulse_without_valid", 1, 0);
    if (!clean_rst && (pkt_valid || frame_err || pkt_err)) begin
      n = int'(pkt_valid) + int'(frame_err) + int'(pkt_err);
      check("pulse_exclusive", n, 1);
      act_kind = pkt_valid ? 0 : (frame_err ? 1 : 2);
      if (exp_q.size() == 0) begin
        check("unexpected_event_kind", act_kind, -1);
      end else begin
        e = exp_q.pop_front();
        $display("RX kind=%0d lane=%0d fire=%0d pulse=%0d proj=%0d rrst=%0d link=%0d",
                 act_kind, lane, fire_level, fire_pulse, proj_type, remote_rst, link_up);
        check("event_kind", act_kind, e.kind);
        check("lane", int'(lane), e.lane);
        check("fire_level", int'(fire_level), e.fire);
        check("fire_pulse", int'(fire_pulse), e.fpulse);
        check("proj_type", int'(proj_type), e.proj);
        check("remote_rst", int'(remote_rst), e.rrst);
        check("link_up", int'(link_up), e.link);
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] b;
    model_reset();
    repeat (5) @(negedge clk);
    check_held("reset");
    clean_rst = 1'b0;
    hold(1'b1, 20);

    // Single fire packet from reset
    send_frame(8'h23, 1'b1, gap_clks());
    // Fire press/release sequence
    send_frame(8'h23, 1'b1, gap_clks());
    send_frame(8'h23, 1'b1, gap_clks());
    send_frame(8'h03, 1'b1, gap_clks());
    send_frame(8'h23, 1'b1, gap_clks());
    // Framing error
    send_frame(8'h15, 1'b0, gap_clks() + BIT_CLKS);
    // Illegal lane code and reserved bit
    send_frame(8'h07, 1'b1, gap_clks());
    send_frame(8'h47, 1'b1, gap_clks());
    // Start-bit glitch must be ignored silently
    hold(1'b0, 40);
    hold(1'b1, 300);
    check_held("after_glitch");

    // Link watchdog
    send_frame(8'h25, 1'b1, 0);
    hold(1'b1, 1700);
    expire();
    check("idle_link_up", int'(link_up), m_link);
    check("idle_fire_level", int'(fire_level), m_fire);
    check("idle_lane", int'(lane), m_lane);

    // Reset after the 4th data bit of 0x05, then the line finishes the frame
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    rx = 1'b0;
    @(negedge clk);
    clean_rst = 1'b1;
    #1;
    model_reset();
    check_held("midframe_reset");
    repeat (2) @(negedge clk);
    clean_rst = 1'b0;
    hold(1'b0, 3 * BIT_CLKS + BIT_CLKS - 3);
    hold(1'b1, BIT_CLKS + 50);
    check_held("after_abort");
    send_frame(8'h95, 1'b1, gap_clks());

    // Random frames, biased toward legal bytes
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        b[6]   = 1'b0;
        b[3:0] = 4'($urandom_range(0, 6));
      end
      send_frame(b, $urandom_range(0, 7) != 0, gap_clks());
    end

    hold(1'b1, 400);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/player_packet_rx.md
PLAYER_PACKET_RX -- requirements
Module: player_packet_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter TIMEOUT_MS, default 50, link-loss watchdog period (used only with PKT_TIMEOUT_EN).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 clean_rst  input  1  reset, asynchronous, active-high.
REQ-006 rx  input  1  UART serial line, idle high, 8N1, LSB first.
REQ-007 lane  output  4  last accepted lane code, 1..6.
REQ-008 fire_level  output  1  fire bit of last accepted packet.
REQ-009 fire_pulse  output  1  one-cycle pulse on each new fire press.
REQ-010 proj_type  output  1  projectile-type bit of last accepted packet.
REQ-011 remote_rst  output  1  reset bit of last accepted packet.
REQ-012 pkt_valid  output  1  one-cycle pulse per accepted packet.
REQ-013 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-014 pkt_err  output  1  one-cycle pulse on well-framed but illegal byte.
REQ-015 link_up  output  1  packets are being received.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-017 SHALL generate a 16x oversample tick every DIV = floor(CLK_HZ/(BAUD*16)) clocks; counter wraps to 0 on tick.
REQ-018 SHALL implement FSM IDLE, START, DATA, STOP; all bit timing counted in ticks.
REQ-019 IDLE -> START on synchronized rx high-to-low transition, only when armed (rx sampled high at least once since reset).
REQ-020 START: at tick 8 rx low -> DATA with tick count cleared; rx high -> IDLE (glitch rejected, no error pulse).
REQ-021 DATA: sample rx every 16 ticks, shift in LSB first; after 8th bit -> STOP.
REQ-022 STOP: sample at 16 ticks; high -> decode byte; low -> frame_err pulse, byte discarded; both -> IDLE.
REQ-023 Byte decode: [7]=remote_rst, [6]=reserved must be 0, [5]=fire, [4]=proj_type, [3:0]=lane code.
REQ-024 Lane code 1..6 -> lane = code; code 0 (sender reset state) -> lane = 3.
REQ-025 Byte[6]=1 or lane code 7..15 -> pkt_err pulse, all held outputs unchanged, no pkt_valid.
REQ-026 Accepted byte -> lane, fire_level, proj_type, remote_rst, pkt_valid updated one clock after stop-bit sample.
REQ-027 fire_pulse SHALL assert for one cycle, with pkt_valid, iff accepted fire=1 and previous fire_level=0.
REQ-028 Error and valid pulses are mutually exclusive; at most one per frame.
REQ-029 New start edge accepted in the cycle after STOP completes; back-to-back frames lose no byte.

Reset
REQ-030 clean_rst SHALL immediately force FSM IDLE, disarmed, tick and bit counters 0, shift register 0.
REQ-031 Reset values: lane=3, fire_level=0, fire_pulse=0, proj_type=0, remote_rst=0, pkt_valid=0, frame_err=0, pkt_err=0, link_up=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no pulses; reception resumes only after rx seen high (REQ-019).

Configuration
REQ-033 Macro PKT_TIMEOUT_EN SHALL select link watchdog behaviour.
REQ-034 With PKT_TIMEOUT_EN: counter cleared on each pkt_valid; link_up=1 on pkt_valid; after CLK_HZ/1000*TIMEOUT_MS clocks without pkt_valid, link_up=0 and fire_level=0 (no fire_pulse generated), lane held.
REQ-035 Without PKT_TIMEOUT_EN: no watchdog logic; link_up set on first pkt_valid and held until reset.

Verification (bench params CLK_HZ=1_600_000, BAUD=10_000, DIV=10, 160 clk/bit, TIMEOUT_MS=1)
REQ-036 Reset, send 0x23 -> one pkt_valid, lane=3, fire_level=1, fire_pulse one cycle, proj_type=0, link_up=1.
REQ-037 Send 0x23, 0x23, 0x03, 0x23 -> fire_pulse only on 1st and 4th packets; fire_level 1,1,0,1.
REQ-038 Send 0x15 with stop bit driven low -> frame_err one cycle, no pkt_valid, lane unchanged.
REQ-039 Send 0x07 then 0x47 -> two pkt_err pulses, no pkt_valid, outputs unchanged; rx low 40 clocks then high -> no pulses, FSM back to IDLE.
REQ-040 Assert clean_rst after 4th data bit of a frame -> lane=3, no pulses; then send 0x95 -> remote_rst=1, proj_type=1, fire_level=0, lane=5.
REQ-041 With PKT_TIMEOUT_EN: send 0x25 then idle 1600 clocks -> link_up=0, fire_level=0, lane=5; without it link_up stays 1.
